// File: rtl/msrv32_load_pipe_unit_if.sv
// Load-request and data-memory signal bundle for the load pipe unit.
// The slave modport is the unit's view; master is the requester/memory side.
interface msrv32_load_pipe_unit_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              load_req_in;
  logic              load_ready_out;
  logic [ADDR_W-1:0] load_addr_in;
  logic [1:0]        load_size_in;
  logic              load_unsigned_in;
  logic              flush_in;
  logic              dmem_req_out;
  logic [ADDR_W-1:0] dmem_addr_out;
  logic              dmem_ack_in;
  logic [WIDTH-1:0]  ms_riscv32_mp_dmdata_in;
  logic              lu_valid_out;
  logic [WIDTH-1:0]  lu_output_out;
  logic              misaligned_out;
  logic              bus_err_out;

  modport slave (
    input  load_req_in, load_addr_in, load_size_in, load_unsigned_in, flush_in,
           dmem_ack_in, ms_riscv32_mp_dmdata_in,
    output load_ready_out, dmem_req_out, dmem_addr_out, lu_valid_out, lu_output_out,
           misaligned_out, bus_err_out
  );

  modport master (
    output load_req_in, load_addr_in, load_size_in, load_unsigned_in, flush_in,
           dmem_ack_in, ms_riscv32_mp_dmdata_in,
    input  load_ready_out, dmem_req_out, dmem_addr_out, lu_valid_out, lu_output_out,
           misaligned_out, bus_err_out
  );
endinterface

// File: rtl/msrv32_load_pipe_unit.sv
// Single-outstanding load unit: alignment check, aligned memory read with timeout,
// byte/half/word/double extraction with sign or zero extension.
module msrv32_load_pipe_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                    ms_riscv32_mp_clk_in,
  input logic                    ms_riscv32_mp_rst_in,
  msrv32_load_pipe_unit_if.slave bus
);
  localparam int unsigned OFS_W = $clog2(WIDTH / 8);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic [OFS_W-1:0]  req_ofs;
  logic              aligned;
  logic [WIDTH-1:0]  shifted, keep, extracted;
  logic              ext_bit;

  assign req_ofs = bus.load_addr_in[OFS_W-1:0];

  always_comb begin
    aligned = 1'b1;
    unique case (bus.load_size_in)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_ofs[0];
      2'b10:   aligned = (req_ofs[1:0] == 2'b00);
      default: aligned = (WIDTH == 64) && (req_ofs == '0);
    endcase
  end

  // Shift the selected lane down to bit 0, then fill everything above it.
  always_comb begin
    shifted = bus.ms_riscv32_mp_dmdata_in >> {ofs_q, 3'b000};
    keep    = '1;
    ext_bit = 1'b0;
    unique case (size_q)
      2'b00: begin
        keep    = WIDTH'(8'hff);
        ext_bit = ~uns_q & shifted[7];
      end
      2'b01: begin
        keep    = WIDTH'(16'hffff);
        ext_bit = ~uns_q & shifted[15];
      end
      2'b10: begin
        keep    = WIDTH'(32'hffff_ffff);
        ext_bit = ~uns_q & shifted[31];
      end
      default: begin
        keep    = '1;
        ext_bit = 1'b0;
      end
    endcase
    extracted = (shifted & keep) | (~keep & {WIDTH{ext_bit}});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ofs_d   = ofs_q;
    size_d  = size_q;
    uns_d   = uns_q;
    valid_d = 1'b0;
    out_d   = out_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load_req_in) begin
          if (aligned) begin
            ofs_d   = req_ofs;
            size_d  = bus.load_size_in;
            uns_d   = bus.load_unsigned_in;
            addr_d  = {bus.load_addr_in[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      StWait: begin
        // Flush outranks both ack and timeout.
        if (bus.flush_in) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (bus.dmem_ack_in) begin
          out_d   = extracted;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          berr_d  = 1'b1;
          req_d   = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ofs_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ofs_q   <= ofs_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.load_ready_out = (state_q == StIdle);
  assign bus.dmem_req_out   = req_q;
  assign bus.dmem_addr_out  = addr_q;
  assign bus.lu_valid_out   = valid_q;
  assign bus.lu_output_out  = out_q;
  assign bus.misaligned_out = mis_q;
  assign bus.bus_err_out    = berr_q;
endmodule
